// File: rtl/muldiv_if.sv
// =============================================================================
// muldiv_if : issue / MTHI-MTLO / flush bundle between EX control and muldiv
// Revision  : 1.0
// =============================================================================
`default_nettype none

interface muldiv_if;
    logic        start;
    logic        is_mult;
    logic        is_multu;
    logic        is_div;
    logic        is_divu;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, is_mult, is_multu, is_div, is_divu, a, b,
        output hi_wen, lo_wen, wdata, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_mult, is_multu, is_div, is_divu, a, b,
        input  hi_wen, lo_wen, wdata, flush,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv.sv
// =============================================================================
// muldiv : multi-cycle multiply / restoring divide unit owning HI and LO
// Revision : 1.0
// =============================================================================
`default_nettype none

module muldiv #(
    parameter int DIV_ITERS = 32
) (
    input  logic     clk,
    input  logic     resetn,
    muldiv_if.slave  bus
);

    localparam int                CNT_W     = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic [31:0]      hi_q,         hi_d;
    logic [31:0]      lo_q,         lo_d;
    logic [31:0]      op_a_q,       op_a_d;
    logic [31:0]      op_b_q,       op_b_d;
    logic             mul_signed_q, mul_signed_d;
    logic [31:0]      rem_q,        rem_d;
    logic [31:0]      quo_q,        quo_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             rem_neg_q,    rem_neg_d;
    logic             quo_neg_q,    quo_neg_d;
    logic             div_zero_q,   div_zero_d;

    logic        w_is_mul_op;
    logic        w_is_div_op;
    logic        w_div_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic        w_trial_ge;
    logic [31:0] w_trial;

    // Op priority: mult > multu > div > divu
    assign w_is_mul_op  = bus.is_mult | bus.is_multu;
    assign w_is_div_op  = ~w_is_mul_op & (bus.is_div | bus.is_divu);
    assign w_div_signed = bus.is_div;
    assign w_a_abs      = (w_div_signed & bus.a[31]) ? -bus.a : bus.a;
    assign w_b_abs      = (w_div_signed & bus.b[31]) ? -bus.b : bus.b;

    // Sign-extending to 64 bits makes one truncated product serve both flavours
    assign w_a_ext = {{32{mul_signed_q & op_a_q[31]}}, op_a_q};
    assign w_b_ext = {{32{mul_signed_q & op_b_q[31]}}, op_b_q};
    assign w_prod  = w_a_ext * w_b_ext;

    // The true difference always fits 32 bits whenever the trial succeeds
    assign w_rem_sh   = {rem_q, quo_q[31]};
    assign w_trial_ge = (w_rem_sh >= {1'b0, op_b_q});
    assign w_trial    = w_rem_sh[31:0] - op_b_q;

    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        hi_d         = hi_q;
        lo_d         = lo_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        mul_signed_d = mul_signed_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        rem_neg_d    = rem_neg_q;
        quo_neg_d    = quo_neg_q;
        div_zero_d   = div_zero_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && w_is_mul_op) begin
                        op_a_d       = bus.a;
                        op_b_d       = bus.b;
                        mul_signed_d = bus.is_mult;
                        state_d      = S_MUL;
                    end else if (bus.start && w_is_div_op) begin
                        op_a_d     = bus.a;
                        op_b_d     = w_b_abs;
                        quo_d      = w_a_abs;
                        rem_d      = 32'd0;
                        cnt_d      = '0;
                        rem_neg_d  = w_div_signed & bus.a[31];
                        quo_neg_d  = w_div_signed & (bus.a[31] ^ bus.b[31]);
                        div_zero_d = (bus.b == 32'd0);
                        state_d    = S_DIV;
                    end
                end
                S_MUL: begin
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                S_DIV: begin
                    rem_d = w_trial_ge ? w_trial : w_rem_sh[31:0];
                    quo_d = {quo_q[30:0], w_trial_ge};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (div_zero_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = op_a_q;
                    end else begin
                        lo_d = quo_neg_q ? -quo_q : quo_q;
                        hi_d = rem_neg_q ? -rem_q : rem_q;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Commits only happen while busy, so MTHI/MTLO never collide with them
        if (!busy_q) begin
            if (bus.hi_wen) hi_d = bus.wdata;
            if (bus.lo_wen) lo_d = bus.wdata;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            mul_signed_q <= 1'b0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            cnt_q        <= '0;
            rem_neg_q    <= 1'b0;
            quo_neg_q    <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            mul_signed_q <= mul_signed_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            cnt_q        <= cnt_d;
            rem_neg_q    <= rem_neg_d;
            quo_neg_q    <= quo_neg_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv.sv
// =============================================================================
// tb_muldiv : self-checking bench for muldiv against an arithmetic reference
// Revision  : 1.0
// =============================================================================
`default_nettype none

module tb_muldiv;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    muldiv_if bus ();

    muldiv #(.DIV_ITERS(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    // ops = {mult, multu, div, divu}; returns {hi, lo}
    function automatic logic [63:0] ref_result(input logic [3:0] ops,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (ops[3]) begin
            res = 64'(sa * sb);
        end else if (ops[2]) begin
            res = ua * ub;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (ops[1]) begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr[31:0], sq[31:0]};
        end else begin
            res = {32'(ua % ub), 32'(ua / ub)};
        end
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            4:       v = 32'($urandom_range(0, 300));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic clear_inputs();
        bus.start    = 1'b0;
        bus.is_mult  = 1'b0;
        bus.is_multu = 1'b0;
        bus.is_div   = 1'b0;
        bus.is_divu  = 1'b0;
        bus.hi_wen   = 1'b0;
        bus.lo_wen   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        {bus.is_mult, bus.is_multu, bus.is_div, bus.is_divu} = ops;
        bus.a = a;
        bus.b = b;
    endtask

    // Called at the negedge of the issue cycle; returns at the negedge of the done cycle
    task automatic do_op(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [63:0] exp;
        int          occ;
        exp = ref_result(ops, a, b);
        occ = (ops[3] | ops[2]) ? 1 : 33;
        drive_op(ops, a, b);
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < occ; c++) begin
            check({tag, " busy"}, 64'(bus.busy), 64'd1);
            check({tag, " done_early"}, 64'(bus.done), 64'd0);
            @(negedge clk);
        end
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " busy_end"}, 64'(bus.busy), 64'd0);
        check({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus.a    = 32'd0;
        bus.b    = 32'd0;
        bus.wdata = 32'd0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);

        do_op(4'b1000, 32'hFFFF_FFFF, 32'd2, "mult");
        do_op(4'b0100, 32'hFFFF_FFFF, 32'd2, "multu");
        do_op(4'b0010, 32'hFFFF_FFF9, 32'd2, "div");
        do_op(4'b0001, 32'hFFFF_FFF9, 32'd2, "divu");
        do_op(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(4'b0001, 32'h0000_1234, 32'd0, "divu_zero");
        do_op(4'b0010, 32'hFFFF_FF00, 32'd0, "div_zero");
        @(negedge clk);
        check("done pulse", 64'(bus.done), 64'd0);

        // MTHI
        bus.hi_wen = 1'b1;
        bus.wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_wen = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'hDEAD_BEEF);
        check("mthi done", 64'(bus.done), 64'd0);

        // lo_wen and start while a divide is busy are ignored
        drive_op(4'b0001, 32'd1000, 32'd7);
        @(negedge clk);
        clear_inputs();
        repeat (4) @(negedge clk);
        bus.lo_wen = 1'b1;
        bus.wdata  = 32'h1111_1111;
        drive_op(4'b1000, 32'd3, 32'd3);
        @(negedge clk);
        clear_inputs();
        check("busy_ign lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
        repeat (28) @(negedge clk);
        check("busy_ign done", 64'(bus.done), 64'd1);
        check("busy_ign hilo", {bus.hi, bus.lo}, {32'd6, 32'd142});

        // lo_wen coincident with start
        bus.lo_wen = 1'b1;
        bus.wdata  = 32'hCAFE_0001;
        drive_op(4'b1000, 32'd5, 32'd5);
        @(negedge clk);
        clear_inputs();
        check("wen_start lo1", 64'(bus.lo), 64'hCAFE_0001);
        @(negedge clk);
        check("wen_start hilo", {bus.hi, bus.lo}, {32'd0, 32'd25});

        // Flush mid-divide
        bus.hi_wen = 1'b1;
        bus.wdata  = 32'hAAAA_AAAA;
        @(negedge clk);
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b1;
        bus.wdata  = 32'h5555_5555;
        @(negedge clk);
        bus.lo_wen = 1'b0;
        drive_op(4'b0010, 32'd100, 32'd7);
        @(negedge clk);
        clear_inputs();
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush done", 64'(bus.done), 64'd0);
        check("flush hilo", {bus.hi, bus.lo}, 64'hAAAA_AAAA_5555_5555);
        do_op(4'b1000, 32'd3, 32'd4, "post_flush");

        // Randomized back-to-back ops, including multi-flag priority
        for (int i = 0; i < 60; i++) begin
            do_op(4'($urandom_range(1, 15)), pick_operand(), pick_operand(), "rand");
        end
        @(negedge clk);
        check("rand done pulse", 64'(bus.done), 64'd0);

        // Reset in the middle of a divide
        drive_op(4'b0010, 32'd12345, 32'd17);
        @(negedge clk);
        clear_inputs();
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid busy", 64'(bus.busy), 64'd0);
        check("rst_mid done", 64'(bus.done), 64'd0);
        check("rst_mid hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_idle busy", 64'(bus.busy), 64'd0);
        check("rst_idle done", 64'(bus.done), 64'd0);
        check("rst_idle hilo", {bus.hi, bus.lo}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv.md
# muldiv

Multi-cycle multiply/divide unit owning the HI/LO architectural registers; sits in EX directly downstream of the ID control decoder. It consumes that decoder's `is_mult`/`is_multu`/`is_div`/`is_divu`/`hi_wen`/`lo_wen` strobes and the forwarded rs/rt operands. MUL/MULT/MULTU complete in one busy cycle; DIV/DIVU use a 32-iteration restoring divider plus one sign-fix cycle. `busy` stalls the front end, and `flush` from exception handling cancels work in flight.

## Interface
- `DIV_ITERS`, default 32: number of restoring-divide iterations, which equals the operand width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `start` in 1: issue strobe, sampled each edge; meaningful only with exactly one op flag set.
- `is_mult`, `is_multu`, `is_div`, `is_divu` in 1 each: operation select. If more than one is set, priority is mult > multu > div > divu.
- `a` in 32: rs_data, the dividend or multiplicand.
- `b` in 32: rt_data, the divisor or multiplier.
- `hi_wen`, `lo_wen` in 1 each: MTHI/MTLO write enables.
- `wdata` in 32: MTHI/MTLO data (rs_data).
- `flush` in 1: cancels any in-progress operation.
- `busy` out 1: registered; high while an operation occupies the unit.
- `done` out 1: registered one-cycle pulse in the first cycle new HI/LO values are visible.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- Reset (async, `resetn`=0): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- States: IDLE, MUL, DIV, FIX.
- **IDLE**
  - `start` with a mult op: latch `a`, `b` and the signed/unsigned flag; go to MUL.
  - `start` with a div op: latch |a|, |b| (abs only for div), the sign of a, sign(a)^sign(b), the raw `a`, and a divide-by-zero flag; clear remainder and counter; go to DIV.
  - `start` with no op flag: ignored.
- **MUL**
  - Form the 64-bit product of the latched operands: signed for mult (which covers MUL), unsigned for multu.
  - {hi,lo} <= product; go to IDLE; `done` is set.
- **DIV**, one restoring iteration per cycle over the 33-bit remainder r and 32-bit quotient q:
  - Shift {r,q} left 1.
  - trial = r − divisor.
  - If trial ≥ 0: r = trial, q[0] = 1.
  - counter++. After iteration DIV_ITERS, go to FIX.
- **FIX**
  - Divide by zero: lo <= 32'hFFFFFFFF, hi <= raw a. No sign fix.
  - Otherwise: lo <= q, negated if the quotient sign is set; hi <= r[31:0], negated if the dividend was negative. The remainder takes the dividend's sign, quotient truncates toward zero.
  - Go to IDLE; `done` is set.
- 0x80000000 / 0xFFFFFFFF (signed) falls out naturally: lo=0x80000000, hi=0.
- **MTHI/MTLO:** `hi_wen`/`lo_wen` write `wdata` at the edge, only when `busy`=0.
  - Wen in the same cycle as `start`: the wen is applied this edge; the operation result overwrites later.
  - Wen while busy: ignored.
- `start` while busy: ignored. The front end must stall on `busy`; the unit does not queue.
- **Flush:**
  - From any state: go to IDLE next edge, `busy`=0, `done`=0, hi/lo unchanged.
  - `flush` with `start` in the same cycle: `start` ignored.
  - `flush` in the FIX cycle: the FIX write is suppressed.
  - `flush` does not block `hi_wen`/`lo_wen` in IDLE.
- `done` is 0 in every cycle except the single cycle after a MUL/FIX commit.

## Timing
- `start` sampled at end of cycle n.
- **Mult:**
  - n+1: MUL, `busy`=1.
  - n+2: new hi/lo visible, `done`=1, `busy`=0.
  - Latency 2, occupancy 1.
- **Div:**
  - n+1..n+32: DIV, `busy`=1.
  - n+33: FIX, `busy`=1.
  - n+34: new hi/lo visible, `done`=1, `busy`=0.
  - Occupancy 33.
- `busy` is registered. The front end must stall on (`busy` | `start` in EX) for a dependent MFHI/MFLO.
- Earliest next `start`: cycle n+2 (mult) or n+34 (div). Back-to-back ops have no bubble beyond that.
- `hi_wen`/`lo_wen` in IDLE: visible next cycle, no `done`.
- Reset mid-operation: immediate IDLE, hi/lo=0.

## Test plan
- **Reset:** assert `resetn`=0 mid-divide → `busy`=0, `done`=0, hi=lo=0 immediately; release, then idle 5 cycles → outputs unchanged.
- **Mult:** a=0xFFFFFFFF, b=2.
  - mult → at n+2 hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done`=1, `busy` high only at n+1.
  - multu → hi=0x00000001, lo=0xFFFFFFFE.
- **Div:**
  - div a=0xFFFFFFF9 (−7), b=2 → `busy` high n+1..n+33; at n+34 lo=0xFFFFFFFD, hi=0xFFFFFFFF, `done`=1.
  - divu same operands → lo=0x7FFFFFFC, hi=0x00000001.
- **Corner divides:**
  - div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - divu 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234.
  - div 0xFFFFFF00/0 → lo=0xFFFFFFFF, hi=0xFFFFFF00.
- **Flush:** preload hi=0xAAAAAAAA, lo=0x55555555; start div 100/7; `flush` at n+10 → `busy`=0 at n+11, no `done` ever, hi/lo unchanged; new mult 3×4 issued at n+11 → lo=12, hi=0 at n+13.
- **MTHI/MTLO and ignore rules:**
  - `hi_wen` with `wdata`=0xDEADBEEF → hi=0xDEADBEEF next cycle.
  - `lo_wen` and `start` asserted during a busy divide → ignored; the divide result is unaffected.
  - `lo_wen` coincident with `start` (mult 5×5) → lo=wdata at n+1, then lo=25 at n+2.
